pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline stage for the RV32I pipeline. It is the successor to the plain enable/reset pipeline registers between IF/ID/EX/MEM/WB. It replaces a global "stale" stall with a per-stage valid/ready handshake backed by a 2-entry skid buffer, so `in_ready` is a registered signal with no combinational path from `out_ready`. It also supports a synchronous flush for branch redirects and saturating stall/bubble performance counters for each stage.

---
 rtl/pipe_stage_elastic.sv | 109 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, and saturating stall/bubble performance counters.
module pipe_stage_elastic #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] stall_count,
    output logic [COUNT_WIDTH-1:0] bubble_count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       main_q, main_d;
    logic [WIDTH-1:0]       skid_q, skid_d;
    logic [COUNT_WIDTH-1:0] stall_q, stall_d;
    logic [COUNT_WIDTH-1:0] bubble_q, bubble_d;
    logic                   in_fire;
    logic                   out_fire;

    // Handshake outputs depend on the state register only
    assign in_ready     = (state_q != S_FULL);
    assign out_valid    = (state_q != S_EMPTY);
    assign out_data     = main_q;
    assign stall_count  = stall_q;
    assign bubble_count = bubble_q;
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready;

    // Occupancy and data movement between input, skid and head registers
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = S_FULL;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // A flushed cycle drops everything held and anything accepted
        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    // Saturating counters; flush does not affect them
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_ONE;
        end
        if (!out_valid && out_ready && bubble_q != CNT_MAX) begin
            bubble_d = bubble_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset taking priority over flush
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic: directed scenarios plus randomized
// stress against a queue-based reference model.
module tb_pipe_stage_elastic;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: default widths, directed tests
    logic        a_reset = 1'b1;
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_out_data;
    logic        a_flush = 1'b0;
    logic [15:0] a_stall;
    logic [15:0] a_bubble;

    // Instance B: narrow data and 4-bit counters
    logic        b_reset = 1'b1;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [8:0]  b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [8:0]  b_out_data;
    logic        b_flush = 1'b0;
    logic [3:0]  b_stall;
    logic [3:0]  b_bubble;

    // Instance C: wide data
    logic        c_reset = 1'b1;
    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [63:0] c_in_data = '0;
    logic        c_out_valid;
    logic        c_out_ready = 1'b0;
    logic [63:0] c_out_data;
    logic        c_flush = 1'b0;
    logic [15:0] c_stall;
    logic [15:0] c_bubble;

    pipe_stage_elastic #(.WIDTH(32), .COUNT_WIDTH(16)) u_a (
        .clock(clock), .reset(a_reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush),
        .stall_count(a_stall), .bubble_count(a_bubble)
    );

    pipe_stage_elastic #(.WIDTH(9), .COUNT_WIDTH(4)) u_b (
        .clock(clock), .reset(b_reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush),
        .stall_count(b_stall), .bubble_count(b_bubble)
    );

    pipe_stage_elastic #(.WIDTH(64), .COUNT_WIDTH(16)) u_c (
        .clock(clock), .reset(c_reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .flush(c_flush),
        .stall_count(c_stall), .bubble_count(c_bubble)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset_a();
        a_reset    = 1'b1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        a_flush    = 1'b0;
        a_in_data  = '0;
        tick();
        a_reset = 1'b0;
    endtask

    task automatic test_reset();
        a_reset    = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 32'h55;
        tick();
        do_reset_a();
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
        end
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
        end
        n_cmp++;
        if (a_out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_out_data: got %h want 0", a_out_data);
        end
        n_cmp++;
        if (a_stall !== 16'd0 || a_bubble !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0",
                     a_stall, a_bubble);
        end
    endtask

    task automatic test_stream();
        do_reset_a();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = i;
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'(i)) begin
                n_err++;
                $display("FAIL stream_beat%0d: got v=%b d=%0h want v=1 d=%0h",
                         i, a_out_valid, a_out_data, i);
            end
        end
        a_in_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_drain: got v=%b want 0", a_out_valid);
        end
        n_cmp++;
        if (a_stall !== 16'd0) begin
            n_err++;
            $display("FAIL stream_stall: got %0d want 0", a_stall);
        end
        n_cmp++;
        if (a_bubble !== 16'd1) begin
            n_err++;
            $display("FAIL stream_bubble: got %0d want 1", a_bubble);
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int got[$];
        int idx;
        idx = 1;
        do_reset_a();
        for (int c = 0; c < 10; c++) begin
            a_out_ready = !(c >= 1 && c <= 3);
            a_in_valid  = (idx <= 4);
            a_in_data   = idx;
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 ||
                    a_out_data !== 32'd1 || idx != 3) begin
                    n_err++;
                    $display("FAIL bp_full_c%0d: got rdy=%b v=%b d=%0h next=%0d want rdy=0 v=1 d=1 next=3",
                             c, a_in_ready, a_out_valid, a_out_data, idx);
                end
            end
            if (a_out_valid && a_out_ready) got.push_back(int'(a_out_data));
            if (a_in_valid && a_in_ready) idx++;
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        n_cmp++;
        if (got.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d beats want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k] != k + 1) begin
                    n_err++;
                    $display("FAIL bp_order%0d: got %0d want %0d",
                             k, got[k], k + 1);
                end
            end
        end
        n_cmp++;
        if (a_stall !== 16'd3) begin
            n_err++;
            $display("FAIL bp_stall: got %0d want 3", a_stall);
        end
    endtask

    task automatic test_flush();
        do_reset_a();
        a_in_valid = 1'b1;
        a_in_data  = 32'hA;
        tick();
        a_in_data = 32'hB;
        tick();
        n_cmp++;
        if (a_in_ready !== 1'b0 || a_out_data !== 32'hA) begin
            n_err++;
            $display("FAIL flush_fill: got rdy=%b d=%0h want rdy=0 d=a",
                     a_in_ready, a_out_data);
        end
        a_flush   = 1'b1;
        a_in_data = 32'hC;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_empty: got v=%b rdy=%b want v=0 rdy=1",
                     a_out_valid, a_in_ready);
        end
        n_cmp++;
        if (a_stall !== 16'd2 || a_bubble !== 16'd0) begin
            n_err++;
            $display("FAIL flush_counters: got %0d/%0d want 2/0",
                     a_stall, a_bubble);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_stays_empty%0d: got v=%b d=%0h want v=0",
                         k, a_out_valid, a_out_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset_a();
        a_in_valid = 1'b1;
        a_in_data  = 32'h1;
        tick();
        a_in_data = 32'h2;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (a_stall !== 16'd5 || a_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_pre: got stall=%0d rdy=%b want 5/0",
                     a_stall, a_in_ready);
        end
        a_reset = 1'b1;
        a_flush = 1'b1;
        tick();
        a_reset = 1'b0;
        a_flush = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
            a_out_data !== 32'h0) begin
            n_err++;
            $display("FAIL rmid_state: got v=%b rdy=%b d=%0h want 0/1/0",
                     a_out_valid, a_in_ready, a_out_data);
        end
        n_cmp++;
        if (a_stall !== 16'd0 || a_bubble !== 16'd0) begin
            n_err++;
            $display("FAIL rmid_counters: got %0d/%0d want 0/0",
                     a_stall, a_bubble);
        end
    endtask

    task automatic test_saturation();
        int exp_b;
        b_reset     = 1'b1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_flush     = 1'b0;
        tick();
        b_reset     = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_b = (k < 15) ? k : 15;
            n_cmp++;
            if (int'(b_bubble) != exp_b) begin
                n_err++;
                $display("FAIL sat_bubble_c%0d: got %0d want %0d",
                         k, b_bubble, exp_b);
            end
        end
        b_out_ready = 1'b0;
    endtask

    task automatic drive(input int sel, input logic r, input logic iv,
                         input logic orr, input logic fl,
                         input logic [63:0] d);
        if (sel == 0) begin
            b_reset = r; b_in_valid = iv; b_out_ready = orr;
            b_flush = fl; b_in_data = d[8:0];
        end else begin
            c_reset = r; c_in_valid = iv; c_out_ready = orr;
            c_flush = fl; c_in_data = d;
        end
    endtask

    task automatic test_random(input int sel);
        logic [63:0] q[$];
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] o_data;
        logic        rst, iv, orr, fl, o_valid, o_ready, m_valid, m_ready;
        int          st, bu, mx, o_st, o_bu;
        mask = (sel == 0) ? 64'h1FF : '1;
        mx   = (sel == 0) ? 15 : 65535;
        st   = 0;
        bu   = 0;
        for (int c = 0; c < 600; c++) begin
            rst = (c == 0) || ($urandom_range(0, 199) == 0);
            iv  = ($urandom_range(0, 99) < 60);
            orr = ($urandom_range(0, 99) < 60);
            fl  = ($urandom_range(0, 99) < 5);
            d   = {$urandom, $urandom} & mask;
            drive(sel, rst, iv, orr, fl, d);
            o_valid = (sel == 0) ? b_out_valid : c_out_valid;
            o_ready = (sel == 0) ? b_in_ready : c_in_ready;
            o_data  = (sel == 0) ? {55'd0, b_out_data} : c_out_data;
            o_st    = (sel == 0) ? int'(b_stall) : int'(c_stall);
            o_bu    = (sel == 0) ? int'(b_bubble) : int'(c_bubble);
            m_valid = (q.size() > 0);
            m_ready = (q.size() < 2);
            if (c > 0) begin
                n_cmp++;
                if (o_valid !== m_valid || o_ready !== m_ready) begin
                    n_err++;
                    $display("FAIL rand%0d_hs_c%0d: got v=%b r=%b want v=%b r=%b",
                             sel, c, o_valid, o_ready, m_valid, m_ready);
                end
                if (m_valid) begin
                    n_cmp++;
                    if (o_data !== q[0]) begin
                        n_err++;
                        $display("FAIL rand%0d_data_c%0d: got %h want %h",
                                 sel, c, o_data, q[0]);
                    end
                end
                n_cmp++;
                if (o_st != st || o_bu != bu) begin
                    n_err++;
                    $display("FAIL rand%0d_cnt_c%0d: got %0d/%0d want %0d/%0d",
                             sel, c, o_st, o_bu, st, bu);
                end
            end
            if (rst) begin
                q.delete();
                st = 0;
                bu = 0;
            end else begin
                if (m_valid && !orr && st < mx) st++;
                if (!m_valid && orr && bu < mx) bu++;
                if (fl) begin
                    q.delete();
                end else begin
                    if (m_valid && orr) void'(q.pop_front());
                    if (iv && m_ready) q.push_back(d);
                end
            end
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    initial begin
        #1;
        tick();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
